// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: prescaled digit scan,
// double-buffered value load committed at frame boundaries, optional leading-zero blanking.
module seven_seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter bit          BLANK_LEAD = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic [15:0] i_value_in,
   input  logic [3:0]  i_dp_in,
   input  logic        i_load,
   output logic        o_ready,
   output logic [7:0]  o_seg,
   output logic [3:0]  o_dig,
   output logic        o_frame_tick
);
   // state   | meaning
   // ST_IDLE | nothing staged; ready=1, a load is accepted
   // ST_PEND | staged value waits for the next frame boundary; ready=0

   localparam int unsigned   PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } load_state_t;

   load_state_t   r_state;
   load_state_t   w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_slot;
   logic [15:0]   r_stage;
   logic [3:0]    r_dp_stage;
   logic [15:0]   r_shadow;
   logic [3:0]    r_dp_shadow;
   logic [7:0]    r_seg;
   logic [3:0]    r_dig;
   logic          r_frame_tick;

   logic          w_wrap;
   logic          w_boundary;
   logic          w_accept;
   logic          w_commit;
   logic [3:0]    w_digit;
   logic          w_dp_sel;
   logic          w_lead_zero;
   logic [6:0]    w_pattern;

   assign w_wrap     = i_enable && (r_presc == PRESC_MAX);
   assign w_boundary = w_wrap && (r_slot == 2'd3);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_presc <= '0;
         r_slot  <= 2'd0;
      end else if (w_wrap) begin
         r_presc <= '0;
         r_slot  <= r_slot + 2'd1;
      end else if (i_enable) begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_load) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            // A load taken in a boundary cycle lands here too late to commit; it waits a full frame.
            if (w_boundary) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage     <= 16'h0000;
         r_dp_stage  <= 4'h0;
         r_shadow    <= 16'h0000;
         r_dp_shadow <= 4'h0;
      end else begin
         if (w_accept) begin
            r_stage    <= i_value_in;
            r_dp_stage <= i_dp_in;
         end
         if (w_commit) begin
            r_shadow    <= r_stage;
            r_dp_shadow <= r_dp_stage;
         end
      end
   end

   always_comb begin
      w_digit     = 4'h0;
      w_dp_sel    = 1'b0;
      w_lead_zero = 1'b0;
      case (r_slot)
         2'd0: begin
            w_digit  = r_shadow[3:0];
            w_dp_sel = r_dp_shadow[0];
         end
         2'd1: begin
            w_digit     = r_shadow[7:4];
            w_dp_sel    = r_dp_shadow[1];
            w_lead_zero = (r_shadow[15:4] == 12'h000);
         end
         2'd2: begin
            w_digit     = r_shadow[11:8];
            w_dp_sel    = r_dp_shadow[2];
            w_lead_zero = (r_shadow[15:8] == 8'h00);
         end
         default: begin
            w_digit     = r_shadow[15:12];
            w_dp_sel    = r_dp_shadow[3];
            w_lead_zero = (r_shadow[15:12] == 4'h0);
         end
      endcase
   end

   // Segment order gfedcba, active-low.
   always_comb begin
      w_pattern = 7'b1111111;
      case (w_digit)
         4'd0:    w_pattern = 7'b1000000;
         4'd1:    w_pattern = 7'b1111001;
         4'd2:    w_pattern = 7'b0100100;
         4'd3:    w_pattern = 7'b0110000;
         4'd4:    w_pattern = 7'b0011001;
         4'd5:    w_pattern = 7'b0010010;
         4'd6:    w_pattern = 7'b0000010;
         4'd7:    w_pattern = 7'b1111000;
         4'd8:    w_pattern = 7'b0000000;
         4'd9:    w_pattern = 7'b0010000;
         default: w_pattern = 7'b1111111;
      endcase
      if (BLANK_LEAD && w_lead_zero) begin
         w_pattern = 7'b1111111;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dig        <= 4'b1111;
         r_seg        <= 8'hFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_boundary;
         if (i_enable) begin
            r_dig <= ~(4'b0001 << r_slot);
            r_seg <= {~w_dp_sel, w_pattern};
         end else begin
            r_dig <= 4'b1111;
            r_seg <= 8'hFF;
         end
      end
   end

   assign o_ready      = (r_state == ST_IDLE);
   assign o_seg        = r_seg;
   assign o_dig        = r_dig;
   assign o_frame_tick = r_frame_tick;

endmodule
